fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end for the RV32I/RV64I core. It owns the fetch PC
//   and issues instruction reads to memory over a req/ack handshake, with one request
//   outstanding at a time. Returned instructions and their PCs are buffered in a DEPTH-entry
//   FIFO, which the decode/control stage drains over a valid/ready interface.
//   Traps, mret/sret and taken branches flush the queue and restart fetch via a redirect.
// PARAMETERS
//   XLEN      32   datapath/address width; 32 or 64
//   DEPTH     4    FIFO entries; power of 2, >= 2
//   RESET_PC  0    fetch PC after reset; bits [1:0] must be 0
// PORTS
//   clock        in   1     system clock; all state updates on rising edge
//   reset        in   1     synchronous, active-low reset
//   fetch_en     in   1     1 = new fetch requests may be issued
//   redirect_en  in   1     flush queue and restart fetch at redirect_pc
//   redirect_pc  in   XLEN  new fetch address; bits [1:0] are ignored (treated as 0)
//   mem_rd_en    out  1     instruction read request
//   mem_addr     out  XLEN  read address; 4-byte aligned
//   mem_ack      in   1     read complete; mem_rd_data is valid in this cycle
//   mem_rd_data  in   32    instruction word
//   inst_valid   out  1     FIFO head holds a valid instruction
//   inst_ready   in   1     consumer takes the head this cycle (valid & ready)
//   inst         out  32    head instruction word
//   inst_pc      out  XLEN  PC of the head instruction
// BEHAVIOUR
//   Reset (reset==0 at an edge): state=IDLE, fetch_pc=RESET_PC, count=0.
//     Outputs: mem_rd_en=0, mem_addr=RESET_PC, inst_valid=0.
//   inst and inst_pc are show-ahead from the head entry. They are don't-care when inst_valid=0.
//   inst_valid=(count!=0), taken from registered state only.
//   FSM states: IDLE, REQ, DISCARD. mem_rd_en and mem_addr are registered.
//   IDLE -> REQ when fetch_en & !redirect_en & (count - pop + 0) < DEPTH.
//     mem_rd_en rises on the next cycle; mem_addr=fetch_pc.
//   REQ: mem_rd_en and mem_addr are held stable until mem_ack.
//     On ack without redirect: push {mem_rd_data, mem_addr}; fetch_pc += 4 (mod 2^XLEN).
//     Next state is REQ (back-to-back) if fetch_en and room remains after this push and
//     pop; otherwise IDLE. Room means count_next < DEPTH.
//     Back-to-back gives a new mem_addr in the cycle after ack.
//   Redirect (highest priority):
//     count -> 0 next cycle. A pop in the same cycle is ignored. A push (ack) in the
//       same cycle is discarded.
//     fetch_pc <- {redirect_pc[XLEN-1:2], 2'b00}.
//     In IDLE, or in REQ with mem_ack=1: go to IDLE. A request for the new PC may issue
//       from the next cycle.
//     In REQ with mem_ack=0: the request is never withdrawn. Go to DISCARD.
//   DISCARD: mem_rd_en and mem_addr are held until mem_ack; the returned data is dropped,
//     then go to IDLE. A further redirect in DISCARD updates fetch_pc (last wins) and
//     flushes the FIFO again.
//   Full: no request issues when count==DEPTH. Because at most one request is outstanding
//     and issue requires count<DEPTH, a push never hits a full FIFO.
//   Pop when empty (inst_ready & !inst_valid) has no effect. Simultaneous push and pop:
//     count is unchanged and the pointers both advance, wrapping mod DEPTH.
//   fetch_en=0 stops new requests only; an outstanding request completes normally.
//   Reset mid-request: mem_rd_en drops on the next cycle; any later mem_ack is ignored
//     in IDLE.
// TESTING
//   1. Reset release, memory acks 1 cycle after each req, inst_ready=1.
//      -> mem_addr sequence 0x0,0x4,0x8,... ; inst_pc values match; no drops or duplicates.
//   2. DEPTH=4, inst_ready=0, ack in the same cycle as the req.
//      -> exactly 4 pushes, then mem_rd_en stays 0. One pop -> exactly one new request.
//   3. redirect_pc=0x100 while a req to 0x8 waits 3 cycles for ack.
//      -> mem_addr holds 0x8 until ack; 0x8 data never appears; next mem_addr=0x100.
//   4. redirect with mem_ack, inst_ready and inst_valid all 1 in the same cycle.
//      -> next cycle inst_valid=0; the acked word is dropped; fetch resumes at redirect_pc.
//   5. XLEN=32, redirect_pc=0xFFFFFFFE.
//      -> fetch at 0xFFFFFFFC then 0x00000000 (wrap); inst_pc values match.
//   6. reset=0 asserted while mem_rd_en=1.
//      -> next cycle mem_rd_en=0, inst_valid=0, mem_addr=RESET_PC; a late mem_ack is ignored.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Memory read handshake and instruction stream of the fetch front end.
// master = fetch_queue side, slave = memory/decode side.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            mem_rd_en;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rd_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output mem_rd_en, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rd_data, inst_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rd_data, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one read at a time and
// buffers returned words with their PCs in a DEPTH-entry show-ahead FIFO.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no request outstanding; issue when enabled and FIFO has room
//   REQ     | request outstanding at mem_addr; ack pushes into the FIFO
//   DISCARD | request outstanding but flushed by a redirect; ack is dropped
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_en,
    input  logic             redirect_en,
    input  logic [XLEN-1:0]  redirect_pc,
    fetch_queue_if.master    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_next;
    logic              req_en, req_en_next;
    logic [XLEN-1:0]   req_addr, req_addr_next;
    logic [31:0]       inst_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              push, pop, room;
    logic [XLEN-1:0]   redirect_base;
    logic              unused_pc_bits;

    assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // A redirect suppresses both FIFO operations of its cycle.
    assign push = (state == REQ) && bus.mem_ack && !redirect_en;
    assign pop  = bus.inst_ready && (count != '0) && !redirect_en;

    always_comb begin
        count_next = redirect_en ? '0 : count - CNT_W'(pop) + CNT_W'(push);
        room       = (count_next < DEPTH_C);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            req_en   <= 1'b0;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            req_en   <= req_en_next;
            req_addr <= req_addr_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fetch_en && !redirect_en && room)
                    state_next = REQ;
            end
            REQ: begin
                if (redirect_en)
                    state_next = bus.mem_ack ? IDLE : DISCARD;
                else if (bus.mem_ack)
                    state_next = (fetch_en && room) ? REQ : IDLE;
            end
            DISCARD: begin
                if (bus.mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect_en)
            fetch_pc_next = redirect_base;
        else if (push)
            fetch_pc_next = fetch_pc + XLEN'(4);

        req_en_next   = (state_next != IDLE);
        // New address only when a fresh request starts; held while outstanding.
        req_addr_next = req_addr;
        if (state_next == REQ && (state == IDLE || push))
            req_addr_next = fetch_pc_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            if (redirect_en) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.mem_rd_data;
            pc_mem[wr_ptr]   <= req_addr;
        end
    end

    assign bus.mem_rd_en  = req_en;
    assign bus.mem_addr   = req_addr;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = inst_mem[rd_ptr];
    assign bus.inst_pc    = pc_mem[rd_ptr];
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked
// against a transaction-level model (expected FIFO contents as a queue).
module tb_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_en;
    logic [31:0] redirect_pc;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_disc;

    int vectors = 0;
    int miscompares = 0;
    int age = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected effect of one clock edge, from the current inputs.
    task automatic model_edge();
        bit ack;
        bit was_disc;
        ent_t e;
        if (!reset) begin
            m_q.delete();
            m_fpc  = RESET_PC;
            m_addr = RESET_PC;
            m_out  = 0;
            m_disc = 0;
            return;
        end
        ack = m_out && bus.mem_ack;
        if (redirect_en) begin
            m_q.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
            if (m_out) begin
                if (ack) begin
                    m_out  = 0;
                    m_disc = 0;
                end else begin
                    m_disc = 1;
                end
            end
        end else begin
            if (bus.inst_ready && m_q.size() != 0)
                void'(m_q.pop_front());
            if (m_out) begin
                if (ack) begin
                    was_disc = m_disc;
                    m_out  = 0;
                    m_disc = 0;
                    if (!was_disc) begin
                        e.pc   = m_addr;
                        e.data = bus.mem_rd_data;
                        m_q.push_back(e);
                        m_fpc = m_fpc + 32'd4;
                        if (fetch_en && m_q.size() < DEPTH) begin
                            m_out  = 1;
                            m_addr = m_fpc;
                        end
                    end
                end
            end else if (fetch_en && m_q.size() < DEPTH) begin
                m_out  = 1;
                m_addr = m_fpc;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_rd_en", {63'd0, bus.mem_rd_en}, {63'd0, m_out});
        if (m_out)
            chk("mem_addr", {32'd0, bus.mem_addr}, {32'd0, m_addr});
        chk("inst_valid", {63'd0, bus.inst_valid}, {63'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("inst", {32'd0, bus.inst}, {32'd0, m_q[0].data});
            chk("inst_pc", {32'd0, bus.inst_pc}, {32'd0, m_q[0].pc});
        end
    endtask

    task automatic step();
        bit ack_seen;
        model_edge();
        ack_seen = bus.mem_ack && bus.mem_rd_en;
        @(posedge clock);
        #1;
        if (!bus.mem_rd_en) age = 0;
        else if (ack_seen) age = 1;
        else age++;
        compare_all();
    endtask

    // Memory answers once the request has been visible for more than lat cycles.
    task automatic auto_ack(input int lat);
        bus.mem_ack     = bus.mem_rd_en && (age > lat);
        bus.mem_rd_data = $urandom;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        redirect_en = 1'b0;
        bus.mem_ack = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int pushes;
        bit found;
        logic [31:0] exp_pc;

        reset = 1'b0;
        fetch_en = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rd_data = '0;
        bus.inst_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
        chk("rst_addr", {32'd0, bus.mem_addr}, {32'd0, RESET_PC});
        chk("rst_valid", {63'd0, bus.inst_valid}, 64'd0);

        // Sequential fetch, ack one cycle after request, consumer always ready
        fetch_en = 1'b1;
        bus.inst_ready = 1'b1;
        exp_pc = 32'h0;
        pops = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.inst_valid) begin
                chk("t1_pc_seq", {32'd0, bus.inst_pc}, {32'd0, exp_pc});
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            auto_ack(1);
            step();
        end
        chk("t1_progress", {63'd0, pops >= 8}, 64'd1);

        // Fill with consumer stalled, same-cycle ack
        do_reset();
        fetch_en = 1'b1;
        bus.inst_ready = 1'b0;
        pushes = 0;
        for (int i = 0; i < 12; i++) begin
            auto_ack(0);
            if (bus.mem_rd_en && bus.mem_ack) pushes++;
            step();
        end
        chk("t2_fill_pushes", 64'(pushes), 64'd4);
        chk("t2_full_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
        bus.mem_ack = 1'b0;
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        pushes = 0;
        for (int i = 0; i < 8; i++) begin
            auto_ack(0);
            if (bus.mem_rd_en && bus.mem_ack) pushes++;
            step();
        end
        chk("t2_refill_pushes", 64'(pushes), 64'd1);

        // Redirect while request to 0x8 is waiting
        do_reset();
        fetch_en = 1'b1;
        bus.inst_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.mem_rd_en && bus.mem_addr == 32'h8) found = 1;
            else begin
                auto_ack(0);
                step();
            end
        end
        chk("t3_reach_0x8", {63'd0, found}, 64'd1);
        bus.mem_ack = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_en = 1'b0;
        chk("t3_hold1", {32'd0, bus.mem_addr}, 64'h8);
        step();
        chk("t3_hold2", {32'd0, bus.mem_addr}, 64'h8);
        chk("t3_hold_en", {63'd0, bus.mem_rd_en}, 64'd1);
        bus.mem_ack = 1'b1;
        bus.mem_rd_data = 32'hDEAD_0008;
        step();
        chk("t3_drop_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("t3_drop_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
        bus.mem_ack = 1'b0;
        step();
        chk("t3_new_addr", {32'd0, bus.mem_addr}, 64'h100);
        bus.mem_ack = 1'b1;
        bus.mem_rd_data = 32'h0000_0100;
        step();
        chk("t3_new_pc", {32'd0, bus.inst_pc}, 64'h100);
        bus.mem_ack = 1'b0;

        // Redirect coinciding with ack, pop and valid head
        do_reset();
        fetch_en = 1'b1;
        bus.inst_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.mem_rd_en && bus.inst_valid) found = 1;
            else begin
                auto_ack(0);
                step();
            end
        end
        chk("t4_setup", {63'd0, found}, 64'd1);
        bus.mem_ack = 1'b1;
        bus.mem_rd_data = 32'h1234_5678;
        bus.inst_ready = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect_en = 1'b0;
        bus.mem_ack = 1'b0;
        chk("t4_valid", {63'd0, bus.inst_valid}, 64'd0);
        step();
        chk("t4_resume", {32'd0, bus.mem_addr}, 64'h200);

        // Address wrap at the top of the 32-bit space
        do_reset();
        fetch_en = 1'b1;
        bus.inst_ready = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_en = 1'b0;
        step();
        chk("t5_addr_top", {32'd0, bus.mem_addr}, 64'hFFFF_FFFC);
        bus.mem_ack = 1'b1;
        bus.mem_rd_data = 32'hAAAA_5555;
        step();
        chk("t5_addr_wrap", {32'd0, bus.mem_addr}, 64'h0);
        chk("t5_pc_top", {32'd0, bus.inst_pc}, 64'hFFFF_FFFC);
        bus.mem_rd_data = 32'h5555_AAAA;
        step();
        chk("t5_pc_wrap", {32'd0, bus.inst_pc}, 64'h0);
        bus.mem_ack = 1'b0;

        // Reset during an outstanding request, then a late ack
        do_reset();
        fetch_en = 1'b1;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            auto_ack(0);
            step();
        end
        bus.mem_ack = 1'b0;
        step();
        chk("t6_pre_rd_en", {63'd0, bus.mem_rd_en}, 64'd1);
        reset = 1'b0;
        step();
        chk("t6_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
        chk("t6_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("t6_addr", {32'd0, bus.mem_addr}, {32'd0, RESET_PC});
        reset = 1'b1;
        fetch_en = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rd_data = 32'hBAD0_BAD0;
        step();
        chk("t6_late_ack", {63'd0, bus.inst_valid}, 64'd0);
        bus.mem_ack = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) != 0);
            fetch_en    = ($urandom_range(0, 7) != 0);
            redirect_en = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            bus.inst_ready  = $urandom_range(0, 1) == 1;
            bus.mem_ack     = bus.mem_rd_en ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 9) == 0);
            bus.mem_rd_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
